fp_norm_pack: RTL



---
 rtl/fp_norm_pack.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fp_norm_pack.sv
// fp_norm_pack: iterative normalizer and IEEE-754 single-precision packer.
// Takes an un-normalized 25-bit significand {carry, hidden, frac[22:0]},
// a biased exponent and a sign. It does one shift per clock and
// produces {sign, exp[7:0], frac[22:0]}. Rounding is by truncation.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   sign, exp, mant     operand: sign, biased exponent, significand
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   out                 packed single-precision result
//   shift_cnt           shift steps used for out (FPNORM_SHIFTCNT_EN only)
//
// Build option: define FPNORM_SHIFTCNT_EN to add the shift_cnt port and its counter.
module fp_norm_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [24:0] mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
`ifdef FPNORM_SHIFTCNT_EN
    ,
    output logic [4:0]  shift_cnt
`endif
);

    localparam int unsigned MANT_W  = 25;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAX_EXP = 255;
    localparam int unsigned FRAC_W  = MANT_W - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [MANT_W-1:0]   m_q;
    logic [EXP_W-1:0]    e_q;
    logic                s_q;

    // Control, datapath and packed output in one registered FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            m_q       <= '0;
            e_q       <= '0;
            s_q       <= 1'b0;
`ifdef FPNORM_SHIFTCNT_EN
            shift_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_q      <= sign;
                        m_q      <= mant;
                        // Exponent 0 has the same scale as exponent 1 (denormal).
                        e_q      <= (exp == '0) ? EXP_W'(1) : exp;
                        state    <= NORM;
                        in_ready <= 1'b0;
`ifdef FPNORM_SHIFTCNT_EN
                        shift_cnt <= '0;
`endif
                    end
                end

                NORM: begin
                    if (e_q == EXP_W'(MAX_EXP)) begin
                        // Inf/NaN: pass the fraction through untouched.
                        out       <= {s_q, e_q, m_q[FRAC_W-1:0]};
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else if (m_q == '0) begin
                        out       <= {s_q, 31'b0};
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else if (m_q[MANT_W-1]) begin
                        if (e_q == EXP_W'(MAX_EXP - 1)) begin
                            // The right shift would reach the Inf exponent.
                            out       <= {s_q, EXP_W'(MAX_EXP), FRAC_W'(0)};
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            m_q <= m_q >> 1;
                            e_q <= e_q + EXP_W'(1);
`ifdef FPNORM_SHIFTCNT_EN
                            shift_cnt <= shift_cnt + 5'd1;
`endif
                        end
                    end else if (m_q[MANT_W-2]) begin
                        out       <= {s_q, e_q, m_q[FRAC_W-1:0]};
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else if (e_q == EXP_W'(1)) begin
                        // Cannot shift below the minimum exponent: denormal result.
                        out       <= {s_q, EXP_W'(0), m_q[FRAC_W-1:0]};
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        m_q <= m_q << 1;
                        e_q <= e_q - EXP_W'(1);
`ifdef FPNORM_SHIFTCNT_EN
                        shift_cnt <= shift_cnt + 5'd1;
`endif
                    end
                end

                DONE: begin
                    // Back to IDLE on the handshake; accept happens next cycle at the earliest.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
